// File: rtl/sa_read_channel_pkg.sv
// Shared definitions for the slave-arbitration read channel and its
// dispatcher-side counterpart.
//   - AXI field widths (burst, len, size, resp)
//   - outst_cnt_w(): width of a counter that must reach 'depth' inclusive
//   - idx_w():       width of an index over n items, never narrower than 1
package sa_read_channel_pkg;

  localparam int AXI_BURST_W = 2;
  localparam int AXI_LEN_W   = 3;
  localparam int AXI_SIZE_W  = 3;
  localparam int AXI_RESP_W  = 2;

  function automatic int outst_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sa_rr_arbiter.sv
// Round-robin arbiter with a registered priority pointer.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_req           request vector, one bit per master
//   i_load_en       downstream can take a grant this cycle
//   o_grant         one-hot grant (combinational, independent of i_load_en)
//   o_grant_idx     encoded index of o_grant
//   o_grant_vld     any request present
// The search starts at the pointer. The pointer moves to the slot after the
// winner only when the grant is actually taken (i_load_en).
module sa_rr_arbiter
  import sa_read_channel_pkg::*;
#(
  parameter int MST_AMT = 2,
  parameter int IDX_W   = idx_w(MST_AMT)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [MST_AMT-1:0] i_req,
  input  logic               i_load_en,
  output logic [MST_AMT-1:0] o_grant,
  output logic [IDX_W-1:0]   o_grant_idx,
  output logic               o_grant_vld
);

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W:0]   w_cand;
  logic [IDX_W:0]   w_ptr_inc;
  logic [IDX_W-1:0] w_ptr_next;

  // Scan MST_AMT slots starting at r_ptr; the first requester wins.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_grant_vld = 1'b0;
    w_cand      = '0;
    for (int k = 0; k < MST_AMT; k++) begin
      w_cand = {1'b0, r_ptr} + (IDX_W+1)'(k);
      if (w_cand >= (IDX_W+1)'(MST_AMT)) begin
        w_cand = w_cand - (IDX_W+1)'(MST_AMT);
      end
      if (!o_grant_vld && i_req[w_cand[IDX_W-1:0]]) begin
        o_grant_vld = 1'b1;
        o_grant_idx = w_cand[IDX_W-1:0];
      end
    end
    if (o_grant_vld) begin
      o_grant[o_grant_idx] = 1'b1;
    end
  end

  assign w_ptr_inc  = {1'b0, o_grant_idx} + (IDX_W+1)'(1);
  assign w_ptr_next = (w_ptr_inc >= (IDX_W+1)'(MST_AMT)) ? '0 : w_ptr_inc[IDX_W-1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (i_load_en && o_grant_vld) begin
      r_ptr <= w_ptr_next;
    end
  end

endmodule

// File: rtl/sa_read_channel.sv
// Slave-arbitration read channel: one instance in front of each slave.
// AR: round-robin arbitration of dispatcher requests into a one-entry
//     registered AR stage towards the slave.
// R:  an in-order FIFO of granted dispatcher indices steers slave R beats
//     (zero latency) to the owner of the oldest outstanding burst; the entry
//     retires on the RLAST handshake. The slave must answer in AR order.
// Ports:
//   ACLK_i, ARESETn_i       clock, asynchronous active-low reset
//   dsp_AR*_i               per-dispatcher AR payload/valid, lane 0 in LSBs
//   dsp_AR_outst_full_i     masks a dispatcher's request
//   dsp_ARREADY_o           AR ready, at most one bit set
//   dsp_R*_o                R payload broadcast to all lanes
//   dsp_RVALID_o            R valid, one-hot to the burst owner
//   dsp_RREADY_i            per-dispatcher R ready
//   s_AR*_o, s_ARREADY_i    registered AR towards the slave
//   s_R*_i, s_RREADY_o      R from the slave
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A valid source holds valid and payload stable until it is taken;
// ready may depend combinationally on valid, valid never depends on ready.
module sa_read_channel
  import sa_read_channel_pkg::*;
#(
  parameter int MST_AMT           = 2,
  parameter int OUTSTANDING_AMT   = 8,
  parameter int DATA_WIDTH        = 32,
  parameter int ADDR_WIDTH        = 32,
  parameter int TRANS_MST_ID_W    = 5,
  parameter int TRANS_BURST_W     = AXI_BURST_W,
  parameter int TRANS_DATA_LEN_W  = AXI_LEN_W,
  parameter int TRANS_DATA_SIZE_W = AXI_SIZE_W,
  parameter int TRANS_WR_RESP_W   = AXI_RESP_W,
  parameter int MST_ID_W          = idx_w(MST_AMT)
) (
  input  logic                                  ACLK_i,
  input  logic                                  ARESETn_i,
  input  logic [TRANS_MST_ID_W*MST_AMT-1:0]     dsp_ARID_i,
  input  logic [ADDR_WIDTH*MST_AMT-1:0]         dsp_ARADDR_i,
  input  logic [TRANS_BURST_W*MST_AMT-1:0]      dsp_ARBURST_i,
  input  logic [TRANS_DATA_LEN_W*MST_AMT-1:0]   dsp_ARLEN_i,
  input  logic [TRANS_DATA_SIZE_W*MST_AMT-1:0]  dsp_ARSIZE_i,
  input  logic [MST_AMT-1:0]                    dsp_ARVALID_i,
  input  logic [MST_AMT-1:0]                    dsp_AR_outst_full_i,
  output logic [MST_AMT-1:0]                    dsp_ARREADY_o,
  output logic [TRANS_MST_ID_W*MST_AMT-1:0]     dsp_RID_o,
  output logic [DATA_WIDTH*MST_AMT-1:0]         dsp_RDATA_o,
  output logic [TRANS_WR_RESP_W*MST_AMT-1:0]    dsp_RRESP_o,
  output logic [MST_AMT-1:0]                    dsp_RLAST_o,
  output logic [MST_AMT-1:0]                    dsp_RVALID_o,
  input  logic [MST_AMT-1:0]                    dsp_RREADY_i,
  output logic [TRANS_MST_ID_W-1:0]             s_ARID_o,
  output logic [ADDR_WIDTH-1:0]                 s_ARADDR_o,
  output logic [TRANS_BURST_W-1:0]              s_ARBURST_o,
  output logic [TRANS_DATA_LEN_W-1:0]           s_ARLEN_o,
  output logic [TRANS_DATA_SIZE_W-1:0]          s_ARSIZE_o,
  output logic                                  s_ARVALID_o,
  input  logic                                  s_ARREADY_i,
  input  logic [TRANS_MST_ID_W-1:0]             s_RID_i,
  input  logic [DATA_WIDTH-1:0]                 s_RDATA_i,
  input  logic [TRANS_WR_RESP_W-1:0]            s_RRESP_i,
  input  logic                                  s_RLAST_i,
  input  logic                                  s_RVALID_i,
  output logic                                  s_RREADY_o
);

  localparam int PTR_W = idx_w(OUTSTANDING_AMT);
  localparam int CNT_W = outst_cnt_w(OUTSTANDING_AMT);

  // ---------------- AR arbitration ----------------
  logic [MST_AMT-1:0]  w_req;
  logic [MST_AMT-1:0]  w_grant;
  logic [MST_ID_W-1:0] w_gidx;
  logic                w_gvld;
  logic                w_load_en;
  logic                w_accept;

  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic                w_pop;

  assign w_req = dsp_ARVALID_i & ~dsp_AR_outst_full_i;

  // A full FIFO still takes a new AR in the cycle its head retires, so the
  // outstanding count can stay pinned at the maximum without a bubble.
  assign w_load_en = (~s_ARVALID_o | s_ARREADY_i) & (~w_fifo_full | w_pop);
  assign w_accept  = w_load_en & w_gvld;

  assign dsp_ARREADY_o = w_grant & {MST_AMT{w_load_en}};

  sa_rr_arbiter #(
    .MST_AMT (MST_AMT),
    .IDX_W   (MST_ID_W)
  ) u_arb (
    .i_clk       (ACLK_i),
    .i_rst_n     (ARESETn_i),
    .i_req       (w_req),
    .i_load_en   (w_load_en),
    .o_grant     (w_grant),
    .o_grant_idx (w_gidx),
    .o_grant_vld (w_gvld)
  );

  // One-hot payload select of the granted lane.
  logic [TRANS_MST_ID_W-1:0]    w_sel_id;
  logic [ADDR_WIDTH-1:0]        w_sel_addr;
  logic [TRANS_BURST_W-1:0]     w_sel_burst;
  logic [TRANS_DATA_LEN_W-1:0]  w_sel_len;
  logic [TRANS_DATA_SIZE_W-1:0] w_sel_size;

  always_comb begin
    w_sel_id    = '0;
    w_sel_addr  = '0;
    w_sel_burst = '0;
    w_sel_len   = '0;
    w_sel_size  = '0;
    for (int i = 0; i < MST_AMT; i++) begin
      if (w_grant[i]) begin
        w_sel_id    = dsp_ARID_i[i*TRANS_MST_ID_W +: TRANS_MST_ID_W];
        w_sel_addr  = dsp_ARADDR_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_burst = dsp_ARBURST_i[i*TRANS_BURST_W +: TRANS_BURST_W];
        w_sel_len   = dsp_ARLEN_i[i*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
        w_sel_size  = dsp_ARSIZE_i[i*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W];
      end
    end
  end

  // ---------------- AR output register ----------------
  logic [TRANS_MST_ID_W-1:0]    r_arid;
  logic [ADDR_WIDTH-1:0]        r_araddr;
  logic [TRANS_BURST_W-1:0]     r_arburst;
  logic [TRANS_DATA_LEN_W-1:0]  r_arlen;
  logic [TRANS_DATA_SIZE_W-1:0] r_arsize;
  logic                         r_arvalid;

  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      r_arid    <= '0;
      r_araddr  <= '0;
      r_arburst <= '0;
      r_arlen   <= '0;
      r_arsize  <= '0;
      r_arvalid <= 1'b0;
    end else if (w_accept) begin
      r_arid    <= w_sel_id;
      r_araddr  <= w_sel_addr;
      r_arburst <= w_sel_burst;
      r_arlen   <= w_sel_len;
      r_arsize  <= w_sel_size;
      r_arvalid <= 1'b1;
    end else if (s_ARREADY_i) begin
      r_arvalid <= 1'b0;
    end
  end

  assign s_ARID_o    = r_arid;
  assign s_ARADDR_o  = r_araddr;
  assign s_ARBURST_o = r_arburst;
  assign s_ARLEN_o   = r_arlen;
  assign s_ARSIZE_o  = r_arsize;
  assign s_ARVALID_o = r_arvalid;

  // ---------------- Order FIFO ----------------
  logic [MST_ID_W-1:0] r_fifo [OUTSTANDING_AMT];
  logic [PTR_W-1:0]    r_wptr;
  logic [PTR_W-1:0]    r_rptr;
  logic [CNT_W-1:0]    r_cnt;
  logic [MST_ID_W-1:0] w_head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUTSTANDING_AMT-1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_fifo_empty = (r_cnt == '0);
  assign w_fifo_full  = (r_cnt == CNT_W'(OUTSTANDING_AMT));
  assign w_head       = r_fifo[r_rptr];

  // Storage needs no reset: entries are only read while the count says valid.
  always_ff @(posedge ACLK_i) begin
    if (w_accept) begin
      r_fifo[r_wptr] <= w_gidx;
    end
  end

  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_accept) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)    r_rptr <= ptr_inc(r_rptr);
      case ({w_accept, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // ---------------- R steering ----------------
  always_comb begin
    dsp_RVALID_o = '0;
    for (int i = 0; i < MST_AMT; i++) begin
      dsp_RVALID_o[i] = ~w_fifo_empty & s_RVALID_i & (w_head == MST_ID_W'(i));
    end
  end

  assign s_RREADY_o = ~w_fifo_empty & dsp_RREADY_i[w_head];
  assign w_pop      = s_RVALID_i & s_RREADY_o & s_RLAST_i;

  assign dsp_RID_o   = {MST_AMT{s_RID_i}};
  assign dsp_RDATA_o = {MST_AMT{s_RDATA_i}};
  assign dsp_RRESP_o = {MST_AMT{s_RRESP_i}};
  assign dsp_RLAST_o = {MST_AMT{s_RLAST_i}};

endmodule

// File: tb/tb_sa_read_channel.sv
// Directed bench for sa_read_channel (2 dispatchers, 8 outstanding).
// Inputs change 1 time unit after the rising edge; outputs are sampled one
// unit later, well before the next edge. exp_q holds the expected owner of
// every accepted burst, in order, and R routing is checked against it.
module tb_sa_read_channel;

  localparam int MST = 2;
  localparam int IDW = 5;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BW  = 2;
  localparam int LW  = 3;
  localparam int SW  = 3;
  localparam int RW  = 2;

  logic                ACLK_i;
  logic                ARESETn_i;
  logic [IDW*MST-1:0]  dsp_ARID_i;
  logic [AW*MST-1:0]   dsp_ARADDR_i;
  logic [BW*MST-1:0]   dsp_ARBURST_i;
  logic [LW*MST-1:0]   dsp_ARLEN_i;
  logic [SW*MST-1:0]   dsp_ARSIZE_i;
  logic [MST-1:0]      dsp_ARVALID_i;
  logic [MST-1:0]      dsp_AR_outst_full_i;
  logic [MST-1:0]      dsp_ARREADY_o;
  logic [IDW*MST-1:0]  dsp_RID_o;
  logic [DW*MST-1:0]   dsp_RDATA_o;
  logic [RW*MST-1:0]   dsp_RRESP_o;
  logic [MST-1:0]      dsp_RLAST_o;
  logic [MST-1:0]      dsp_RVALID_o;
  logic [MST-1:0]      dsp_RREADY_i;
  logic [IDW-1:0]      s_ARID_o;
  logic [AW-1:0]       s_ARADDR_o;
  logic [BW-1:0]       s_ARBURST_o;
  logic [LW-1:0]       s_ARLEN_o;
  logic [SW-1:0]       s_ARSIZE_o;
  logic                s_ARVALID_o;
  logic                s_ARREADY_i;
  logic [IDW-1:0]      s_RID_i;
  logic [DW-1:0]       s_RDATA_i;
  logic [RW-1:0]       s_RRESP_i;
  logic                s_RLAST_i;
  logic                s_RVALID_i;
  logic                s_RREADY_o;

  sa_read_channel dut (
    .ACLK_i              (ACLK_i),
    .ARESETn_i           (ARESETn_i),
    .dsp_ARID_i          (dsp_ARID_i),
    .dsp_ARADDR_i        (dsp_ARADDR_i),
    .dsp_ARBURST_i       (dsp_ARBURST_i),
    .dsp_ARLEN_i         (dsp_ARLEN_i),
    .dsp_ARSIZE_i        (dsp_ARSIZE_i),
    .dsp_ARVALID_i       (dsp_ARVALID_i),
    .dsp_AR_outst_full_i (dsp_AR_outst_full_i),
    .dsp_ARREADY_o       (dsp_ARREADY_o),
    .dsp_RID_o           (dsp_RID_o),
    .dsp_RDATA_o         (dsp_RDATA_o),
    .dsp_RRESP_o         (dsp_RRESP_o),
    .dsp_RLAST_o         (dsp_RLAST_o),
    .dsp_RVALID_o        (dsp_RVALID_o),
    .dsp_RREADY_i        (dsp_RREADY_i),
    .s_ARID_o            (s_ARID_o),
    .s_ARADDR_o          (s_ARADDR_o),
    .s_ARBURST_o         (s_ARBURST_o),
    .s_ARLEN_o           (s_ARLEN_o),
    .s_ARSIZE_o          (s_ARSIZE_o),
    .s_ARVALID_o         (s_ARVALID_o),
    .s_ARREADY_i         (s_ARREADY_i),
    .s_RID_i             (s_RID_i),
    .s_RDATA_i           (s_RDATA_i),
    .s_RRESP_i           (s_RRESP_i),
    .s_RLAST_i           (s_RLAST_i),
    .s_RVALID_i          (s_RVALID_i),
    .s_RREADY_o          (s_RREADY_o)
  );

  // ---------------- clock / reset ----------------
  initial begin
    ACLK_i = 1'b0;
    forever #5 ACLK_i = ~ACLK_i;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [0:0] exp_q[$];
  logic [0:0] owner;
  logic [31:0] beat_data;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge ACLK_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_ar(input int m, input logic [IDW-1:0] id,
                        input logic [AW-1:0] addr, input logic [LW-1:0] len);
    dsp_ARID_i[m*IDW +: IDW]  = id;
    dsp_ARADDR_i[m*AW +: AW]  = addr;
    dsp_ARBURST_i[m*BW +: BW] = 2'b01;
    dsp_ARLEN_i[m*LW +: LW]   = len;
    dsp_ARSIZE_i[m*SW +: SW]  = 3'b010;
    dsp_ARVALID_i[m]          = 1'b1;
  endtask

  task automatic clr_ar();
    dsp_ARVALID_i = '0;
  endtask

  task automatic r_drive(input logic vld, input logic last,
                         input logic [DW-1:0] data, input logic [MST-1:0] rdy);
    s_RVALID_i   = vld;
    s_RLAST_i    = last;
    s_RDATA_i    = data;
    s_RID_i      = 5'd1;
    s_RRESP_i    = 2'b00;
    dsp_RREADY_i = rdy;
  endtask

  // Play one burst of 'beats' beats; every beat must go to the expected owner.
  task automatic drain_burst(input int beats);
    chk("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
    owner = exp_q.pop_front();
    for (int b = 0; b < beats; b++) begin
      beat_data = 32'hD000_0000 + 32'($urandom_range(0, 16'hFFFF));
      r_drive(1'b1, (b == beats - 1), beat_data, 2'b11);
      settle();
      chk("r_valid_route", 64'(dsp_RVALID_o), 64'(2'b01 << owner));
      chk("r_ready", 64'(s_RREADY_o), 64'd1);
      chk("r_data_bcast", 64'(dsp_RDATA_o), {beat_data, beat_data});
      step();
    end
    r_drive(1'b0, 1'b0, '0, 2'b00);
  endtask

  // A beat offered with nothing outstanding must stall.
  task automatic check_empty();
    r_drive(1'b1, 1'b1, 32'hDEAD_BEEF, 2'b11);
    settle();
    chk("empty_rvalid", 64'(dsp_RVALID_o), 64'd0);
    chk("empty_rready", 64'(s_RREADY_o), 64'd0);
    step();
    r_drive(1'b0, 1'b0, '0, 2'b00);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    ARESETn_i           = 1'b0;
    dsp_ARID_i          = '0;
    dsp_ARADDR_i        = '0;
    dsp_ARBURST_i       = '0;
    dsp_ARLEN_i         = '0;
    dsp_ARSIZE_i        = '0;
    dsp_ARVALID_i       = '0;
    dsp_AR_outst_full_i = '0;
    s_ARREADY_i         = 1'b0;
    r_drive(1'b1, 1'b1, 32'h1, 2'b11);

    // Reset state
    repeat (3) step();
    settle();
    chk("rst_arvalid", 64'(s_ARVALID_o), 64'd0);
    chk("rst_araddr", 64'(s_ARADDR_o), 64'd0);
    chk("rst_rvalid", 64'(dsp_RVALID_o), 64'd0);
    chk("rst_rready", 64'(s_RREADY_o), 64'd0);
    step();
    r_drive(1'b0, 1'b0, '0, 2'b00);
    ARESETn_i = 1'b1;
    step();

    // 1: single AR from dsp0, 4-beat burst
    s_ARREADY_i = 1'b1;
    set_ar(0, 5'd3, 32'h4000_0000, 3'd3);
    settle();
    chk("t1_arready", 64'(dsp_ARREADY_o), 64'(2'b01));
    exp_q.push_back(1'b0);
    step();
    clr_ar();
    chk("t1_s_arvalid", 64'(s_ARVALID_o), 64'd1);
    chk("t1_s_arid", 64'(s_ARID_o), 64'd3);
    chk("t1_s_araddr", 64'(s_ARADDR_o), 64'h4000_0000);
    chk("t1_s_arlen", 64'(s_ARLEN_o), 64'd3);
    drain_burst(4);
    check_empty();

    // 2: both request continuously; pointer sits at 1 after test 1
    set_ar(0, 5'd5, 32'h0000_1000, 3'd1);
    set_ar(1, 5'd9, 32'h0000_2000, 3'd1);
    for (int n = 0; n < 4; n++) begin
      settle();
      chk("t2_grant", 64'(dsp_ARREADY_o), (n % 2 == 0) ? 64'(2'b10) : 64'(2'b01));
      exp_q.push_back((n % 2 == 0) ? 1'b1 : 1'b0);
      step();
      chk("t2_s_arvalid", 64'(s_ARVALID_o), 64'd1);
      chk("t2_s_arid", 64'(s_ARID_o), (n % 2 == 0) ? 64'd9 : 64'd5);
    end
    clr_ar();
    step();
    for (int n = 0; n < 4; n++) drain_burst(2);
    check_empty();

    // 3: slave stalls AR for 5 cycles; then R ready held low by the owner
    s_ARREADY_i = 1'b0;
    set_ar(1, 5'd7, 32'h0000_1234, 3'd0);
    settle();
    chk("t3_grant", 64'(dsp_ARREADY_o), 64'(2'b10));
    exp_q.push_back(1'b1);
    step();
    clr_ar();
    set_ar(0, 5'd6, 32'h0000_5678, 3'd0);
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("t3_hold_arready", 64'(dsp_ARREADY_o), 64'd0);
      chk("t3_hold_arvalid", 64'(s_ARVALID_o), 64'd1);
      chk("t3_hold_araddr", 64'(s_ARADDR_o), 64'h1234);
      step();
    end
    s_ARREADY_i = 1'b1;
    settle();
    chk("t3_release_grant", 64'(dsp_ARREADY_o), 64'(2'b01));
    exp_q.push_back(1'b0);
    step();
    clr_ar();
    chk("t3_next_araddr", 64'(s_ARADDR_o), 64'h5678);
    step();
    owner = exp_q.pop_front();
    for (int k = 0; k < 2; k++) begin
      r_drive(1'b1, 1'b1, 32'h0000_0077, 2'b01);
      settle();
      chk("t3_rhold_rvalid", 64'(dsp_RVALID_o), 64'(2'b01 << owner));
      chk("t3_rhold_rready", 64'(s_RREADY_o), 64'd0);
      step();
    end
    r_drive(1'b1, 1'b1, 32'h0000_0077, 2'b11);
    settle();
    chk("t3_rel_rready", 64'(s_RREADY_o), 64'd1);
    step();
    r_drive(1'b0, 1'b0, '0, 2'b00);
    drain_burst(1);
    check_empty();

    // 4: fill the order FIFO, block, then pop+push in one cycle
    set_ar(1, 5'd11, 32'h0000_8000, 3'd0);
    for (int n = 0; n < 8; n++) begin
      settle();
      chk("t4_fill_grant", 64'(dsp_ARREADY_o), 64'(2'b10));
      exp_q.push_back(1'b1);
      step();
    end
    settle();
    chk("t4_full_block", 64'(dsp_ARREADY_o), 64'd0);
    step();
    settle();
    chk("t4_full_block2", 64'(dsp_ARREADY_o), 64'd0);
    r_drive(1'b1, 1'b1, 32'h0000_0088, 2'b11);
    settle();
    chk("t4_pop_rvalid", 64'(dsp_RVALID_o), 64'(2'b10));
    chk("t4_pop_grant", 64'(dsp_ARREADY_o), 64'(2'b10));
    step();
    void'(exp_q.pop_front());
    exp_q.push_back(1'b1);
    r_drive(1'b0, 1'b0, '0, 2'b00);
    settle();
    chk("t4_still_full", 64'(dsp_ARREADY_o), 64'd0);
    clr_ar();
    step();
    for (int n = 0; n < 8; n++) drain_burst(1);
    check_empty();

    // 5: dispatcher 0 masked by outstanding-full
    set_ar(0, 5'd12, 32'h0000_C000, 3'd0);
    set_ar(1, 5'd13, 32'h0000_D000, 3'd0);
    dsp_AR_outst_full_i = 2'b01;
    settle();
    chk("t5_masked_grant", 64'(dsp_ARREADY_o), 64'(2'b10));
    exp_q.push_back(1'b1);
    step();
    clr_ar();
    dsp_AR_outst_full_i = 2'b00;
    chk("t5_s_arid", 64'(s_ARID_o), 64'd13);
    drain_burst(1);

    // 6: reset in the middle of a burst, then normal operation
    set_ar(0, 5'd2, 32'h0000_A000, 3'd3);
    settle();
    chk("t6_grant", 64'(dsp_ARREADY_o), 64'(2'b01));
    exp_q.push_back(1'b0);
    step();
    clr_ar();
    s_ARREADY_i = 1'b0;
    for (int b = 0; b < 2; b++) begin
      r_drive(1'b1, 1'b0, 32'h0000_0100 + 32'(b), 2'b11);
      settle();
      chk("t6_beat_route", 64'(dsp_RVALID_o), 64'(2'b01));
      step();
    end
    chk("t6_pre_arvalid", 64'(s_ARVALID_o), 64'd1);
    ARESETn_i = 1'b0;
    settle();
    chk("t6_rst_arvalid", 64'(s_ARVALID_o), 64'd0);
    chk("t6_rst_rvalid", 64'(dsp_RVALID_o), 64'd0);
    chk("t6_rst_rready", 64'(s_RREADY_o), 64'd0);
    exp_q.delete();
    step();
    r_drive(1'b0, 1'b0, '0, 2'b00);
    ARESETn_i   = 1'b1;
    s_ARREADY_i = 1'b1;
    step();
    set_ar(1, 5'd4, 32'h0000_B000, 3'd0);
    settle();
    chk("t6_post_grant", 64'(dsp_ARREADY_o), 64'(2'b10));
    exp_q.push_back(1'b1);
    step();
    clr_ar();
    chk("t6_post_arvalid", 64'(s_ARVALID_o), 64'd1);
    chk("t6_post_araddr", 64'(s_ARADDR_o), 64'h0000_B000);
    drain_burst(1);
    check_empty();

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
